rgmii_udp_rx_parser: RTL and testbench



---
 rtl/rgmii_pkg.sv | 58 +++++
 rtl/rgmii_hdr_check.sv | 33 +++
 rtl/rgmii_udp_rx_parser.sv | 213 +++++++++++++++++++++
 tb/tb_rgmii_udp_rx_parser.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_pkg.sv
// Shared types for the RGMII UDP datapath: on-wire header layout, config registers,
// receive status and the RX parser state encoding.
package rgmii_pkg;

    localparam int          HEADER_BYTES  = 42;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL  = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
    localparam logic [15:0] UDP_HDR_BYTES = 16'd8;

    // Fields in wire order; wire byte k is byte k of the struct counted from the MSB end,
    // so every multi-byte field reads big-endian.
    typedef struct packed {
        logic [47:0] mac_destination;
        logic [47:0] mac_source;
        logic [15:0] eth_type_length;
        logic [7:0]  version_ihl;
        logic [7:0]  tos;
        logic [15:0] total_length;
        logic [15:0] identification;
        logic [15:0] flags_fragment;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [15:0] header_checksum;
        logic [31:0] ip_source;
        logic [31:0] ip_destination;
        logic [15:0] port_source;
        logic [15:0] port_destination;
        logic [15:0] udp_length;
        logic [15:0] udp_checksum;
    } ethernet_header_t;

    typedef struct packed { logic [47:0] fpga; } mac_cfg_t;
    typedef struct packed { logic [31:0] fpga; } ip_cfg_t;
    typedef struct packed { logic [15:0] fpga; } port_cfg_t;
    typedef struct packed { logic check_destination; } control_cfg_t;

    typedef struct packed {
        mac_cfg_t     mac;
        ip_cfg_t      ip;
        port_cfg_t    port;
        control_cfg_t control;
    } rgmii_config_t;

    typedef struct packed {
        logic crc_err;
        logic truncated;
        logic dropped;
    } rx_stat_t;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DISCARD = 2'd3
    } rx_state_t;

endpackage

// File: rtl/rgmii_hdr_check.sv
// Combinational accept decision for a captured Ethernet/IPv4/UDP header against the
// local configuration; shared between the RX parser and the TX loopback bench.
module rgmii_hdr_check
    import rgmii_pkg::*;
#(
    parameter bit CHECK_BROADCAST = 1'b1
) (
    input  ethernet_header_t hdr_i,
    input  rgmii_config_t    cfg_i,
    output logic             accept_o
);

    logic proto_ok;
    logic mac_ok;
    logic dest_ok;
    logic unused_hdr_bits;

    always_comb begin
        proto_ok = (hdr_i.eth_type_length == ETH_TYPE_IPV4) &&
                   (hdr_i.version_ihl == IPV4_VER_IHL) &&
                   (hdr_i.protocol == IP_PROTO_UDP) &&
                   (hdr_i.udp_length >= UDP_HDR_BYTES);
        mac_ok   = (hdr_i.mac_destination == cfg_i.mac.fpga) ||
                   (CHECK_BROADCAST && (hdr_i.mac_destination == 48'hFFFF_FFFF_FFFF));
        dest_ok  = mac_ok &&
                   (hdr_i.ip_destination == cfg_i.ip.fpga) &&
                   (hdr_i.port_destination == cfg_i.port.fpga);
        accept_o = proto_ok && (!cfg_i.control.check_destination || dest_ok);
    end

    assign unused_hdr_bits = ^hdr_i;

endmodule

// File: rtl/rgmii_udp_rx_parser.sv
// Receive-side UDP frame parser: captures the 42-byte header, validates it, forwards
// only the UDP payload and reports per-frame status and saturating frame counters.
module rgmii_udp_rx_parser
    import rgmii_pkg::*;
#(
    parameter bit CHECK_BROADCAST = 1'b1,
    parameter int CNT_W           = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  rgmii_config_t    cfg_i,
    // s_valid_i qualifies s_data_i/s_last_i/s_crc_err_i on every cycle and cannot be
    // stalled; m_valid_o likewise qualifies m_data_o/m_last_o with no backpressure.
    input  logic [7:0]       s_data_i,
    input  logic             s_valid_i,
    input  logic             s_last_i,
    input  logic             s_crc_err_i,
    output logic [7:0]       m_data_o,
    output logic             m_valid_o,
    output logic             m_last_o,
    output logic             hdr_valid_o,
    output logic [47:0]      hdr_src_mac_o,
    output logic [31:0]      hdr_src_ip_o,
    output logic [15:0]      hdr_src_port_o,
    output logic [15:0]      hdr_len_o,
    output logic             stat_valid_o,
    output logic [2:0]       stat_o,
    output logic [CNT_W-1:0] frames_ok_o,
    output logic [CNT_W-1:0] frames_drop_o
);

    localparam int HDR_W = HEADER_BYTES * 8;

    rx_state_t          state_q, state_d;
    logic [5:0]         hdr_cnt_q, hdr_cnt_d;
    logic [HDR_W-1:0]   hdr_q, hdr_d, hdr_wr;
    logic [15:0]        pay_cnt_q, pay_cnt_d;
    logic               trunc_q, trunc_d, drop_q, drop_d;
    logic [7:0]         m_data_q, m_data_d;
    logic               m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic               hdr_valid_q, hdr_valid_d;
    logic [47:0]        src_mac_q, src_mac_d;
    logic [31:0]        src_ip_q, src_ip_d;
    logic [15:0]        src_port_q, src_port_d, hdr_len_q, hdr_len_d;
    logic               stat_valid_q, stat_valid_d;
    rx_stat_t           stat_q, stat_d;
    logic [CNT_W-1:0]   ok_cnt_q, ok_cnt_d, drop_cnt_q, drop_cnt_d;
    logic               eof, trunc_now, drop_now, accept;
    ethernet_header_t   hdr_s;

    // Header image including the byte arriving this cycle, so byte 41 is checked on arrival.
    always_comb begin
        hdr_wr = hdr_q;
        hdr_wr[8*(HEADER_BYTES-1-int'(hdr_cnt_q)) +: 8] = s_data_i;
    end

    assign hdr_s = ethernet_header_t'(hdr_wr);

    rgmii_hdr_check #(.CHECK_BROADCAST(CHECK_BROADCAST)) u_hdr_check (
        .hdr_i    (hdr_s),
        .cfg_i    (cfg_i),
        .accept_o (accept)
    );

    always_comb begin
        state_d      = state_q;
        hdr_cnt_d    = hdr_cnt_q;
        hdr_d        = hdr_q;
        pay_cnt_d    = pay_cnt_q;
        trunc_d      = trunc_q;
        drop_d       = drop_q;
        m_data_d     = m_data_q;
        m_valid_d    = 1'b0;
        m_last_d     = 1'b0;
        hdr_valid_d  = 1'b0;
        src_mac_d    = src_mac_q;
        src_ip_d     = src_ip_q;
        src_port_d   = src_port_q;
        hdr_len_d    = hdr_len_q;
        stat_valid_d = 1'b0;
        stat_d       = stat_q;
        ok_cnt_d     = ok_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        eof          = 1'b0;
        trunc_now    = 1'b0;
        drop_now     = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (!s_valid_i) state_d = ST_HEADER;
            end
            ST_HEADER: begin
                if (s_valid_i) begin
                    hdr_d     = hdr_wr;
                    hdr_cnt_d = hdr_cnt_q + 6'd1;
                    if (s_last_i) begin
                        trunc_now = 1'b1;
                        drop_now  = 1'b1;
                        eof       = 1'b1;
                        hdr_cnt_d = 6'd0;
                    end else if (hdr_cnt_q == 6'(HEADER_BYTES - 1)) begin
                        hdr_cnt_d = 6'd0;
                        pay_cnt_d = 16'd0;
                        if (accept) begin
                            hdr_valid_d = 1'b1;
                            src_mac_d   = hdr_s.mac_source;
                            src_ip_d    = hdr_s.ip_source;
                            src_port_d  = hdr_s.port_source;
                            hdr_len_d   = hdr_s.udp_length - UDP_HDR_BYTES;
                            state_d     = (hdr_len_d == 16'd0) ? ST_DISCARD : ST_PAYLOAD;
                        end else begin
                            drop_d  = 1'b1;
                            state_d = ST_DISCARD;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (s_valid_i) begin
                    pay_cnt_d = pay_cnt_q + 16'd1;
                    m_valid_d = 1'b1;
                    m_data_d  = s_data_i;
                    if (s_last_i) begin
                        m_last_d  = 1'b1;
                        eof       = 1'b1;
                        trunc_now = (pay_cnt_d != hdr_len_q);
                        state_d   = ST_HEADER;
                    end else if (pay_cnt_d == hdr_len_q) begin
                        m_last_d = 1'b1;
                        state_d  = ST_DISCARD;
                    end
                end
            end
            ST_DISCARD: begin
                if (s_valid_i && s_last_i) begin
                    eof     = 1'b1;
                    state_d = ST_HEADER;
                end
            end
            default: state_d = ST_SYNC;
        endcase

        if (eof) begin
            stat_valid_d     = 1'b1;
            stat_d.crc_err   = s_crc_err_i;
            stat_d.truncated = trunc_q | trunc_now;
            stat_d.dropped   = drop_q | drop_now;
            trunc_d          = 1'b0;
            drop_d           = 1'b0;
            if (!stat_d.dropped && !s_crc_err_i) begin
                if (~&ok_cnt_q) ok_cnt_d = ok_cnt_q + CNT_W'(1);
            end else begin
                if (~&drop_cnt_q) drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_SYNC;
            hdr_cnt_q    <= '0;
            hdr_q        <= '0;
            pay_cnt_q    <= '0;
            trunc_q      <= 1'b0;
            drop_q       <= 1'b0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            hdr_valid_q  <= 1'b0;
            src_mac_q    <= '0;
            src_ip_q     <= '0;
            src_port_q   <= '0;
            hdr_len_q    <= '0;
            stat_valid_q <= 1'b0;
            stat_q       <= '0;
            ok_cnt_q     <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            hdr_cnt_q    <= hdr_cnt_d;
            hdr_q        <= hdr_d;
            pay_cnt_q    <= pay_cnt_d;
            trunc_q      <= trunc_d;
            drop_q       <= drop_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            hdr_valid_q  <= hdr_valid_d;
            src_mac_q    <= src_mac_d;
            src_ip_q     <= src_ip_d;
            src_port_q   <= src_port_d;
            hdr_len_q    <= hdr_len_d;
            stat_valid_q <= stat_valid_d;
            stat_q       <= stat_d;
            ok_cnt_q     <= ok_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign m_data_o       = m_data_q;
    assign m_valid_o      = m_valid_q;
    assign m_last_o       = m_last_q;
    assign hdr_valid_o    = hdr_valid_q;
    assign hdr_src_mac_o  = src_mac_q;
    assign hdr_src_ip_o   = src_ip_q;
    assign hdr_src_port_o = src_port_q;
    assign hdr_len_o      = hdr_len_q;
    assign stat_valid_o   = stat_valid_q;
    assign stat_o         = stat_q;
    assign frames_ok_o    = ok_cnt_q;
    assign frames_drop_o  = drop_cnt_q;

endmodule

// File: tb/tb_rgmii_udp_rx_parser.sv
// Bench for rgmii_udp_rx_parser: directed scenarios plus randomized frames, checked
// against a frame-level model of the expected header, payload and status events.
module tb_rgmii_udp_rx_parser;
    import rgmii_pkg::*;

    localparam logic [47:0] MY_MAC  = 48'h02_00_00_00_00_01;
    localparam logic [31:0] MY_IP   = 32'hC0A8_010A;
    localparam logic [15:0] MY_PORT = 16'd5000;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    rgmii_config_t cfg_i;
    logic [7:0]    s_data_i = '0;
    logic          s_valid_i = 1'b0, s_last_i = 1'b0, s_crc_err_i = 1'b0;
    logic [7:0]    m_data_o;
    logic          m_valid_o, m_last_o, hdr_valid_o, stat_valid_o;
    logic [47:0]   hdr_src_mac_o;
    logic [31:0]   hdr_src_ip_o;
    logic [15:0]   hdr_src_port_o, hdr_len_o;
    logic [2:0]    stat_o;
    logic [15:0]   frames_ok_o, frames_drop_o;

    rgmii_udp_rx_parser #(.CHECK_BROADCAST(1'b1), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .cfg_i(cfg_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i), .s_crc_err_i(s_crc_err_i),
        .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o),
        .hdr_valid_o(hdr_valid_o), .hdr_src_mac_o(hdr_src_mac_o), .hdr_src_ip_o(hdr_src_ip_o),
        .hdr_src_port_o(hdr_src_port_o), .hdr_len_o(hdr_len_o),
        .stat_valid_o(stat_valid_o), .stat_o(stat_o),
        .frames_ok_o(frames_ok_o), .frames_drop_o(frames_drop_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]   frame_q[$];
    logic [8:0]   exp_pay_q[$];
    logic [111:0] exp_hdr_q[$];
    logic [34:0]  exp_stat_q[$];
    logic [2:0]   stat_hist[$];

    logic [47:0]  src_mac;
    logic [31:0]  src_ip;
    logic [15:0]  src_port;
    logic [15:0]  m_ok = '0, m_drop = '0;
    logic [15:0]  cur_ok = '0, cur_drop = '0;
    logic [8:0]   last_pay = '0;
    logic [111:0] last_hdr = '0;
    logic [2:0]   last_stat = '0;
    int           pay_beats = 0, hdr_pulses = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s: output pulse with no expected event (t=%0t)", name, $time);
    endtask

    // ---------------- frame construction ----------------
    task automatic push_n(input logic [47:0] v, input int nbytes);
        for (int i = nbytes - 1; i >= 0; i--) frame_q.push_back(v[8*i +: 8]);
    endtask

    task automatic build_frame(input logic [47:0] dmac, input logic [31:0] dip,
                               input logic [15:0] dport, input logic [15:0] ulen);
        frame_q.delete();
        src_mac  = {16'($urandom), $urandom};
        src_ip   = $urandom;
        src_port = 16'($urandom);
        push_n(dmac, 6);
        push_n(src_mac, 6);
        push_n(48'h0800, 2);
        push_n(48'h45, 1);
        push_n(48'h00, 1);
        push_n(48'(ulen + 16'd20), 2);
        push_n(48'($urandom_range(0, 65535)), 2);
        push_n(48'h4000, 2);
        push_n(48'd64, 1);
        push_n(48'h11, 1);
        push_n(48'($urandom_range(0, 65535)), 2);
        push_n(48'(src_ip), 4);
        push_n(48'(dip), 4);
        push_n(48'(src_port), 2);
        push_n(48'(dport), 2);
        push_n(48'(ulen), 2);
        push_n(48'h0000, 2);
    endtask

    task automatic add_fixed();
        push_n(48'hDEADBEEF, 4);
    endtask

    task automatic add_random(input int n);
        for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
    endtask

    task automatic add_pad(input int n);
        for (int i = 0; i < n; i++) frame_q.push_back(8'h00);
    endtask

    // ---------------- reference model (whole-frame view) ----------------
    task automatic run_model(input logic crc);
        int n, avail, plen, fwd;
        logic [47:0] dmac, smac;
        logic [31:0] sip, dip;
        logic [15:0] etype, sport, dport, ulen;
        logic [7:0]  ver, proto;
        logic        acc;
        logic [2:0]  st;
        n = frame_q.size();
        if (n <= HEADER_BYTES) begin
            st = {crc, 2'b11};
        end else begin
            dmac = '0; smac = '0; sip = '0; dip = '0;
            for (int i = 0; i < 6; i++) begin
                dmac = (dmac << 8) | 48'(frame_q[i]);
                smac = (smac << 8) | 48'(frame_q[6 + i]);
            end
            for (int i = 0; i < 4; i++) begin
                sip = (sip << 8) | 32'(frame_q[26 + i]);
                dip = (dip << 8) | 32'(frame_q[30 + i]);
            end
            etype = {frame_q[12], frame_q[13]};
            ver   = frame_q[14];
            proto = frame_q[23];
            sport = {frame_q[34], frame_q[35]};
            dport = {frame_q[36], frame_q[37]};
            ulen  = {frame_q[38], frame_q[39]};
            acc = (etype == 16'h0800) && (ver == 8'h45) && (proto == 8'h11) && (ulen >= 16'd8);
            if (cfg_i.control.check_destination)
                acc = acc && ((dmac == cfg_i.mac.fpga) || (dmac == 48'hFFFF_FFFF_FFFF)) &&
                      (dip == cfg_i.ip.fpga) && (dport == cfg_i.port.fpga);
            if (!acc) begin
                st = {crc, 2'b01};
            end else begin
                plen  = int'(ulen) - 8;
                avail = n - HEADER_BYTES;
                fwd   = (avail < plen) ? avail : plen;
                exp_hdr_q.push_back({smac, sip, sport, 16'(plen)});
                for (int k = 0; k < fwd; k++)
                    exp_pay_q.push_back({(k == fwd - 1), frame_q[HEADER_BYTES + k]});
                st = {crc, (avail < plen), 1'b0};
            end
        end
        if (!st[0] && !crc) begin
            if (m_ok != 16'hFFFF) m_ok++;
        end else begin
            if (m_drop != 16'hFFFF) m_drop++;
        end
        exp_stat_q.push_back({m_ok, m_drop, st});
    endtask

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            s_valid_i   = 1'b0;
            s_last_i    = 1'b0;
            s_data_i    = 8'($urandom);
            s_crc_err_i = 1'($urandom_range(0, 1));
            rst_i       = 1'b0;
        end
    endtask

    task automatic drive_frame(input logic crc, input bit gaps, input int rst_at);
        int n;
        n = frame_q.size();
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 1));
            @(posedge clk); #1;
            s_valid_i   = 1'b1;
            s_data_i    = frame_q[i];
            s_last_i    = (i == n - 1);
            s_crc_err_i = (i == n - 1) ? crc : 1'($urandom_range(0, 1));
            rst_i       = (i == rst_at);
        end
    endtask

    task automatic send(input logic crc, input bit gaps, input int gap_after);
        run_model(crc);
        drive_frame(crc, gaps, -1);
        if (gap_after > 0) idle(gap_after);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_i) begin
            cur_ok   = '0;
            cur_drop = '0;
        end else begin
            if (m_valid_o) begin
                pay_beats++;
                last_pay = {m_last_o, m_data_o};
                if (exp_pay_q.size() == 0) unexpected("payload");
                else check("payload", {m_last_o, m_data_o}, exp_pay_q.pop_front());
            end else begin
                check("last_without_valid", m_last_o, 1'b0);
            end
            if (hdr_valid_o) begin
                hdr_pulses++;
                last_hdr = {hdr_src_mac_o, hdr_src_ip_o, hdr_src_port_o, hdr_len_o};
                if (exp_hdr_q.size() == 0) unexpected("hdr");
                else check("hdr", last_hdr, exp_hdr_q.pop_front());
            end
            if (stat_valid_o) begin
                last_stat = stat_o;
                stat_hist.push_back(stat_o);
                if (exp_stat_q.size() == 0) unexpected("stat");
                else begin
                    logic [34:0] e;
                    e = exp_stat_q.pop_front();
                    check("stat_and_counters", {frames_ok_o, frames_drop_o, stat_o}, e);
                    cur_ok   = e[34:19];
                    cur_drop = e[18:3];
                end
            end else begin
                check("counters_hold", {frames_ok_o, frames_drop_o}, {cur_ok, cur_drop});
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int r;
        cfg_i.mac.fpga = MY_MAC;
        cfg_i.ip.fpga = MY_IP;
        cfg_i.port.fpga = MY_PORT;
        cfg_i.control.check_destination = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_m_valid", m_valid_o, 1'b0);
        check("reset_hdr_valid", hdr_valid_o, 1'b0);
        check("reset_stat_valid", stat_valid_o, 1'b0);
        check("reset_hdr_fields", {hdr_src_mac_o, hdr_src_ip_o, hdr_src_port_o, hdr_len_o}, '0);
        check("reset_counters", {frames_ok_o, frames_drop_o, stat_o, m_data_o, m_last_o}, '0);
        idle(3);

        // basic valid frame
        build_frame(MY_MAC, MY_IP, MY_PORT, 16'd12); add_fixed();
        send(1'b0, 1'b0, 6);
        check("t1_ok", frames_ok_o, 16'd1);
        check("t1_hdr_len", last_hdr[15:0], 16'd4);
        check("t1_last_byte", last_pay, 9'h1EF);
        check("t1_stat", last_stat, 3'b000);
        check("t1_beats", pay_beats, 4);

        // padding not forwarded
        build_frame(MY_MAC, MY_IP, MY_PORT, 16'd12); add_fixed(); add_pad(18);
        send(1'b0, 1'b1, 6);
        check("t2_beats", pay_beats, 8);
        check("t2_stat", last_stat, 3'b000);

        // wrong port, then same frame with destination check off
        build_frame(MY_MAC, MY_IP, 16'd5001, 16'd12); add_fixed(); add_pad(18);
        send(1'b0, 1'b0, 6);
        check("t3_stat", last_stat, 3'b001);
        check("t3_drop", frames_drop_o, 16'd1);
        check("t3_beats", pay_beats, 8);
        cfg_i.control.check_destination = 1'b0;
        send(1'b0, 1'b0, 6);
        check("t3b_stat", last_stat, 3'b000);
        check("t3b_beats", pay_beats, 12);
        cfg_i.control.check_destination = 1'b1;

        // truncated frame followed back-to-back by a good one
        build_frame(MY_MAC, MY_IP, MY_PORT, 16'd12); add_fixed(); add_pad(18);
        while (frame_q.size() > 20) void'(frame_q.pop_back());
        run_model(1'b0);
        drive_frame(1'b0, 1'b0, -1);
        build_frame(MY_MAC, MY_IP, MY_PORT, 16'd12); add_fixed();
        send(1'b0, 1'b0, 6);
        check("t4_trunc_stat", stat_hist[stat_hist.size() - 2], 3'b011);
        check("t4_next_stat", last_stat, 3'b000);
        check("t4_hdr_pulses", hdr_pulses, 4);
        check("t4_counters", {frames_ok_o, frames_drop_o}, {16'd4, 16'd2});

        // crc error: payload still forwarded
        build_frame(MY_MAC, MY_IP, MY_PORT, 16'd12); add_fixed();
        send(1'b1, 1'b0, 6);
        check("t5_stat", last_stat, 3'b100);
        check("t5_drop", frames_drop_o, 16'd3);
        check("t5_beats", pay_beats, 20);

        // zero-length payload, broadcast destination
        build_frame(MY_MAC, MY_IP, MY_PORT, 16'd8); add_pad(10);
        send(1'b0, 1'b0, 6);
        check("t6_len0", last_hdr[15:0], 16'd0);
        check("t6_beats", pay_beats, 20);
        check("t6_ok", frames_ok_o, 16'd5);
        build_frame(48'hFFFF_FFFF_FFFF, MY_IP, MY_PORT, 16'd12); add_fixed();
        send(1'b0, 1'b0, 6);
        check("t6_bcast_ok", frames_ok_o, 16'd6);

        // reset in the middle of a frame
        m_ok = '0; m_drop = '0;
        build_frame(MY_MAC, MY_IP, MY_PORT, 16'd12); add_fixed(); add_pad(18);
        drive_frame(1'b0, 1'b0, 30);
        idle(1);
        build_frame(MY_MAC, MY_IP, MY_PORT, 16'd12); add_fixed();
        send(1'b0, 1'b0, 6);
        check("t7_counters", {frames_ok_o, frames_drop_o}, {16'd1, 16'd0});
        check("t7_stat", last_stat, 3'b000);

        // randomized frames
        for (int f = 0; f < 60; f++) begin
            logic [47:0] dmac;
            logic [31:0] dip;
            logic [15:0] dport;
            dmac = MY_MAC; dip = MY_IP; dport = MY_PORT;
            r = $urandom_range(0, 7);
            if (r == 0) dmac = MY_MAC ^ 48'h1;
            if (r == 1) dip = MY_IP ^ 32'h100;
            if (r == 2) dport = MY_PORT + 16'd1;
            if (r == 3) dmac = 48'hFFFF_FFFF_FFFF;
            cfg_i.control.check_destination = ($urandom_range(0, 3) != 0);
            build_frame(dmac, dip, dport, 16'($urandom_range(0, 30)));
            add_random($urandom_range(0, 30));
            add_pad($urandom_range(0, 6));
            r = $urandom_range(0, 9);
            if (r == 0) frame_q[12] = 8'h86;
            if (r == 1) frame_q[14] = 8'h46;
            if (r == 2) frame_q[23] = 8'h06;
            if ($urandom_range(0, 5) == 0)
                while (frame_q.size() > 1 && $urandom_range(0, 3) != 0) void'(frame_q.pop_back());
            send(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end
        idle(10);

        check("pay_queue_empty", exp_pay_q.size(), 0);
        check("hdr_queue_empty", exp_hdr_q.size(), 0);
        check("stat_queue_empty", exp_stat_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
